// File: rtl/page_buffer_reader.sv
// Streaming read engine for the 2048x8 NAND page buffer: issues column reads and
// presents the bytes in order on a valid/ready stream through a small skid FIFO.
module page_buffer_reader #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_col,
    input  logic [ADDR_W:0]   byte_count,
    input  logic              abort,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_clk_en,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [CNT_W-1:0]  PAGE_C  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);
    localparam logic [FCNT_W-1:0] DEPTH_C = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    state_t              state_r;
    logic [ADDR_W-1:0]   col_r;
    logic [CNT_W-1:0]    count_r;
    logic [CNT_W-1:0]    issued_r;
    logic [CNT_W-1:0]    delivered_r;
    logic                pend_r;
    logic [DATA_W-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [FCNT_W-1:0]   fifo_cnt_r;
    logic [ADDR_W-1:0]   ram_addr_r;
    logic                ram_clk_en_r;
    logic [DATA_W-1:0]   out_data_r;
    logic                out_valid_r;
    logic                out_last_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;

    logic                pop_s;
    logic                legal_s;
    logic                idle_ok_s;
    logic                start_ok_s;
    logic                start_bad_s;
    logic                abort_s;
    logic                last_pop_s;
    state_t              state_nx_s;
    logic [ADDR_W-1:0]   col_nx_s;
    logic [CNT_W-1:0]    count_nx_s;
    logic [CNT_W-1:0]    issued_nx_s;
    logic [CNT_W-1:0]    delivered_nx_s;
    logic                pend_nx_s;
    logic [FCNT_W-1:0]   fifo_cnt_nx_s;
    logic [FCNT_W-1:0]   occ_s;
    logic [FCNT_W-1:0]   remain_s;
    logic                issue_nx_s;
    logic [ADDR_W-1:0]   addr_nx_s;
    logic [PTR_W-1:0]    rd_ptr_nx_s;
    logic [PTR_W-1:0]    wr_ptr_nx_s;
    logic [DATA_W-1:0]   head_s;
    logic                out_valid_nx_s;
    logic                out_last_nx_s;
    logic                done_nx_s;
    logic                busy_nx_s;

    assign ram_addr   = ram_addr_r;
    assign ram_clk_en = ram_clk_en_r;
    assign ram_we     = 1'b0;
    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign out_last   = out_last_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;

    // Next-state computation; read issue is decided one cycle ahead so ram_clk_en is a flop.
    always_comb begin
        pop_s       = out_valid_r & out_ready;
        idle_ok_s   = (state_r == ST_IDLE) && !done_r;
        legal_s     = (byte_count != '0) && (byte_count <= PAGE_C);
        start_ok_s  = start && !abort && idle_ok_s && legal_s;
        start_bad_s = start && !abort && idle_ok_s && !legal_s;
        abort_s     = abort && (state_r != ST_IDLE);
        last_pop_s  = pop_s && (delivered_r == count_r - ONE_C);

        col_nx_s       = start_ok_s ? start_col : col_r;
        count_nx_s     = start_ok_s ? byte_count : count_r;
        issued_nx_s    = start_ok_s ? '0 : issued_r + {{(CNT_W-1){1'b0}}, ram_clk_en_r};
        delivered_nx_s = start_ok_s ? '0 : delivered_r + {{(CNT_W-1){1'b0}}, pop_s};

        state_nx_s = state_r;
        if (abort_s) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:   state_nx_s = start_ok_s ? ST_STREAM : ST_IDLE;
                ST_STREAM: state_nx_s = (ram_clk_en_r && (issued_nx_s == count_r)) ? ST_DRAIN : ST_STREAM;
                ST_DRAIN:  state_nx_s = last_pop_s ? ST_IDLE : ST_DRAIN;
                default:   state_nx_s = ST_IDLE;
            endcase
        end

        // A read issued this cycle lands in the FIFO next cycle, so it still reserves a slot.
        pend_nx_s     = ram_clk_en_r && !abort_s;
        fifo_cnt_nx_s = abort_s ? '0 :
                        fifo_cnt_r + {{(FCNT_W-1){1'b0}}, pend_r} - {{(FCNT_W-1){1'b0}}, pop_s};
        occ_s         = fifo_cnt_nx_s + {{(FCNT_W-1){1'b0}}, pend_nx_s};
        issue_nx_s    = (state_nx_s == ST_STREAM) && (issued_nx_s < count_nx_s) && (occ_s < DEPTH_C);
        addr_nx_s     = col_nx_s + issued_nx_s[ADDR_W-1:0];

        rd_ptr_nx_s = abort_s ? '0 : (pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r);
        wr_ptr_nx_s = abort_s ? '0 : (pend_r ? ptr_inc(wr_ptr_r) : wr_ptr_r);
        remain_s    = fifo_cnt_r - {{(FCNT_W-1){1'b0}}, pop_s};
        head_s      = (remain_s == '0) ? ram_q : fifo_mem_r[rd_ptr_nx_s];

        out_valid_nx_s = (fifo_cnt_nx_s != '0);
        out_last_nx_s  = out_valid_nx_s && (delivered_nx_s == count_r - ONE_C);
        done_nx_s      = last_pop_s && !abort_s;
        busy_nx_s      = (state_nx_s != ST_IDLE) || done_nx_s;
    end

    // State, FIFO storage and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            col_r        <= '0;
            count_r      <= '0;
            issued_r     <= '0;
            delivered_r  <= '0;
            pend_r       <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fifo_cnt_r   <= '0;
            ram_addr_r   <= '0;
            ram_clk_en_r <= 1'b0;
            out_data_r   <= '0;
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            col_r        <= col_nx_s;
            count_r      <= count_nx_s;
            issued_r     <= issued_nx_s;
            delivered_r  <= delivered_nx_s;
            pend_r       <= pend_nx_s;
            if (pend_r && !abort_s) begin
                fifo_mem_r[wr_ptr_r] <= ram_q;
            end
            wr_ptr_r     <= wr_ptr_nx_s;
            rd_ptr_r     <= rd_ptr_nx_s;
            fifo_cnt_r   <= fifo_cnt_nx_s;
            ram_clk_en_r <= issue_nx_s;
            if (issue_nx_s) begin
                ram_addr_r <= addr_nx_s;
            end
            out_valid_r  <= out_valid_nx_s;
            if (out_valid_nx_s) begin
                out_data_r <= head_s;
            end
            out_last_r   <= out_last_nx_s;
            busy_r       <= busy_nx_s;
            done_r       <= done_nx_s;
            err_r        <= start_bad_s;
        end
    end

endmodule
